vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA timing generator.
- Porch, sync and active widths, sync polarity and counter width are parameters.
- A pixel clock-enable allows running from a faster system clock.
- Adds single-cycle line_start/frame_start strobes for downstream pixel generators and frame-synchronous logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync asserted level
- CNT_W, 10, width of hcount/vcount

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_ce  in  1  pixel clock-enable; timing advances only on cycles with pix_ce=1
- hcount  out  CNT_W  current horizontal position
- vcount  out  CNT_W  current line
- vga_active  out  1  current position inside visible area
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- line_start  out  1  one-clk strobe when hcount steps to 0
- frame_start  out  1  one-clk strobe when (hcount,vcount) steps to (0,0)

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high on rst; clk and rst named as in the rest of the codebase.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration: fail if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, or if any width parameter is 0.
- Output registers: all outputs are registers; decoded flags always correspond to the hcount/vcount values presented in the same cycle. Zero extra latency between counters and flags.
- Reset values:
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1 (last pixel of back porch).
  - vga_active = 0, hsync = ~H_POL, vsync = ~V_POL.
  - line_start = 0, frame_start = 0.
- First pix_ce after reset yields hcount=0, vcount=0, vga_active=1, line_start=1, frame_start=1.
- Counter stepping (pix_ce=1):
  - hcount = hcount+1, wrapping H_TOTAL-1 -> 0.
  - On the hcount wrap, vcount = vcount+1, wrapping V_TOTAL-1 -> 0.
- pix_ce=0: hcount, vcount, vga_active, hsync and vsync hold. line_start and frame_start drop to 0, so strobes are one clk wide regardless of pix_ce duty.
- vga_active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- hsync asserted (=H_POL) for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync asserted (=V_POL) for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491). Transitions are aligned with hcount=0 of the line.
- Strobes:
  - line_start = 1 in the cycle hcount becomes 0.
  - frame_start = 1 only when hcount and vcount both become 0; line_start is also 1 then.
- Reset mid-frame: the next clk with rst=1 forces reset values regardless of pix_ce. rst has priority over pix_ce.
- Arithmetic: comparisons are unsigned at CNT_W. There are no intermediate overflow paths because the counters never exceed the totals.

Optional Feature:
- Macro: VGA_TIMING_PREFETCH_EN
- Defined: adds outputs next_hcount[CNT_W], next_vcount[CNT_W] and next_active[1].
  - These carry the values hcount/vcount/vga_active will take on the next pix_ce. They are registered and updated under the same rules, so that synchronous-read framebuffer RAMs with 1-cycle latency line up with vga_active.
  - Reset values: 0, 0, 1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then pix_ce=1 continuously: after rst drop the first cycle gives hcount=0, vcount=0, vga_active=1, line_start=1, frame_start=1; during rst hsync=vsync=1 (defaults).
- Free-run 420000 pix_ce: hsync low exactly for hcount 656..751; vsync low exactly for vcount 490..491; vga_active high for 640x480 = 307200 cycles per frame; frame_start once per 420000 pix_ce; line_start once per 800.
- pix_ce 1-in-4 pattern: counters advance once per 4 clk; line_start/frame_start are exactly 1 clk wide; frame period is 1,680,000 clk.
- Assert rst for 1 clk at hcount=300, vcount=200: next cycle hcount=799, vcount=524, all flags inactive; next pix_ce gives (0,0) with frame_start=1.
- H_POL=1, V_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, CNT_W=11: hsync high for hcount 840..967, vsync high for vcount 601..604, H_TOTAL=1056, V_TOTAL=628.
- With VGA_TIMING_PREFETCH_EN: every cycle where pix_ce=1, the next hcount/vcount/vga_active equal the prior next_hcount/next_vcount/next_active.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable and line/frame strobes.
// Define VGA_TIMING_PREFETCH_EN to add next_hcount/next_vcount/next_active look-ahead outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             vga_active,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CNT_W-1:0] next_hcount,
  output logic [CNT_W-1:0] next_vcount,
  output logic             next_active
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 || CNT_W <= 0) begin : g_bad_width
      $error("vga_timing_gen: every porch, sync, active and counter width must be non-zero");
    end
    if ((H_TOTAL - 1) >= (64'd1 << CNT_W) || (V_TOTAL - 1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             H_ON   = (H_POL != 0);
  localparam logic             V_ON   = (V_POL != 0);

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] x,
                                                input logic [CNT_W-1:0] last);
    return (x == last) ? '0 : x + CNT_W'(1);
  endfunction

  function automatic logic is_active(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] h_step, v_step;
  logic             h_wrap;

  // Flags are decoded from the position being loaded, so they are never a cycle behind it.
  always_comb begin
    h_wrap = (hcount_q == H_LAST);
    h_step = wrap_inc(hcount_q, H_LAST);
    v_step = h_wrap ? wrap_inc(vcount_q, V_LAST) : vcount_q;

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_ce) begin
      hcount_d      = h_step;
      vcount_d      = v_step;
      active_d      = is_active(h_step, v_step);
      hsync_d       = ((h_step >= HS_BEG) && (h_step < HS_END)) ? H_ON : ~H_ON;
      vsync_d       = ((v_step >= VS_BEG) && (v_step < VS_END)) ? V_ON : ~V_ON;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && (vcount_q == V_LAST);
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0] next_h_q, next_h_d;
  logic [CNT_W-1:0] next_v_q, next_v_d;
  logic             next_act_q, next_act_d;

  // Look-ahead position runs one step ahead of the visible counters.
  always_comb begin
    next_h_d   = next_h_q;
    next_v_d   = next_v_q;
    next_act_d = next_act_q;
    if (pix_ce) begin
      next_h_d   = wrap_inc(h_step, H_LAST);
      next_v_d   = (h_step == H_LAST) ? wrap_inc(v_step, V_LAST) : v_step;
      next_act_d = is_active(next_h_d, next_v_d);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      active_q      <= 1'b0;
      hsync_q       <= ~H_ON;
      vsync_q       <= ~V_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_PREFETCH_EN
      next_h_q      <= '0;
      next_v_q      <= '0;
      next_act_q    <= 1'b1;
`endif
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_PREFETCH_EN
      next_h_q      <= next_h_d;
      next_v_q      <= next_v_d;
      next_act_q    <= next_act_d;
`endif
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign vga_active  = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_PREFETCH_EN
  assign next_hcount = next_h_q;
  assign next_vcount = next_v_q;
  assign next_active = next_act_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/edge spot checks, plus a tiny
// 13x9 raster (H_POL=1, V_POL=0, CNT_W=4) for whole-frame, clock-enable and reset checks.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst;
  logic pix_ce;
  always #5 clk = ~clk;

  logic [9:0] d_hcount, d_vcount;
  logic       d_active, d_hsync, d_vsync, d_ls, d_fs;
  logic [3:0] s_hcount, s_vcount;
  logic       s_active, s_hsync, s_vsync, s_ls, s_fs;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [9:0] d_next_h, d_next_v;
  logic       d_next_a;
  logic [3:0] s_next_h, s_next_v, p_next_h, p_next_v;
  logic       s_next_a, p_next_a;
`endif

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hcount(d_hcount), .vcount(d_vcount), .vga_active(d_active),
    .hsync(d_hsync), .vsync(d_vsync), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .next_hcount(d_next_h), .next_vcount(d_next_v), .next_active(d_next_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1), .V_POL(0), .CNT_W(4)
  ) u_small (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hcount(s_hcount), .vcount(s_vcount), .vga_active(s_active),
    .hsync(s_hsync), .vsync(s_vsync), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .next_hcount(s_next_h), .next_vcount(s_next_v), .next_active(s_next_a)
`endif
  );

  int checks_cnt = 0;
  int errors_cnt = 0;
  int s = -1;  // pix_ce steps of the small raster since (0,0)
  int k = -1;  // pix_ce steps of the default raster since (0,0)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic ce);
    pix_ce = ce;
`ifdef VGA_TIMING_PREFETCH_EN
    p_next_h = s_next_h; p_next_v = s_next_v; p_next_a = s_next_a;
`endif
    @(posedge clk);
    #1;
    if (ce) begin
      s++;
      k++;
    end
  endtask

  task automatic check_small(input logic ce);
    int sh;
    int sv;
    sh = s % 13;
    sv = (s / 13) % 9;
    check("s_hcount", 32'(s_hcount), sh);
    check("s_vcount", 32'(s_vcount), sv);
    check("s_active", 32'(s_active), 32'(sh < 6 && sv < 4));
    check("s_hsync",  32'(s_hsync),  32'(sh >= 8 && sh < 11));
    check("s_vsync",  32'(s_vsync),  32'(!(sv >= 5 && sv < 7)));
    check("s_line_start",  32'(s_ls), 32'(ce && sh == 0));
    check("s_frame_start", 32'(s_fs), 32'(ce && sh == 0 && sv == 0));
`ifdef VGA_TIMING_PREFETCH_EN
    if (ce) begin
      check("pf_h_follow", 32'(s_hcount), 32'(p_next_h));
      check("pf_v_follow", 32'(s_vcount), 32'(p_next_v));
      check("pf_a_follow", 32'(s_active), 32'(p_next_a));
    end
    check("pf_next_h", 32'(s_next_h), (sh + 1) % 13);
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_d_hcount"}, 32'(d_hcount), 799);
    check({tag, "_d_vcount"}, 32'(d_vcount), 524);
    check({tag, "_d_active"}, 32'(d_active), 0);
    check({tag, "_d_hsync"},  32'(d_hsync), 1);
    check({tag, "_d_vsync"},  32'(d_vsync), 1);
    check({tag, "_d_ls"},     32'(d_ls), 0);
    check({tag, "_d_fs"},     32'(d_fs), 0);
    check({tag, "_s_hcount"}, 32'(s_hcount), 12);
    check({tag, "_s_vcount"}, 32'(s_vcount), 8);
    check({tag, "_s_active"}, 32'(s_active), 0);
    check({tag, "_s_hsync"},  32'(s_hsync), 0);
    check({tag, "_s_vsync"},  32'(s_vsync), 1);
    check({tag, "_s_ls"},     32'(s_ls), 0);
    check({tag, "_s_fs"},     32'(s_fs), 0);
`ifdef VGA_TIMING_PREFETCH_EN
    check({tag, "_pf_d_h"}, 32'(d_next_h), 0);
    check({tag, "_pf_d_v"}, 32'(d_next_v), 0);
    check({tag, "_pf_d_a"}, 32'(d_next_a), 1);
    check({tag, "_pf_s_a"}, 32'(s_next_a), 1);
`endif
  endtask

  initial begin
    int act_n, hs_n, vs_n, ls_n, fs_n, guard, fs_clk;
    act_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; fs_n = 0;

    rst = 1'b1;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

    // Continuous pix_ce: one small frame counted, default raster up to line 1.
    for (int i = 0; i < 806; i++) begin
      cycle(1'b1);
      check_small(1'b1);
      if (s < 117) begin
        act_n += int'(s_active);
        hs_n  += int'(s_hsync);
        vs_n  += int'(!s_vsync);
        ls_n  += int'(s_ls);
        fs_n  += int'(s_fs);
      end
      if (k == 0) begin
        check("d_first_h", 32'(d_hcount), 0);
        check("d_first_v", 32'(d_vcount), 0);
        check("d_first_act", 32'(d_active), 1);
        check("d_first_ls", 32'(d_ls), 1);
        check("d_first_fs", 32'(d_fs), 1);
        check("d_first_hs", 32'(d_hsync), 1);
        check("d_first_vs", 32'(d_vsync), 1);
      end
      if (k == 639) check("d_act_639", 32'(d_active), 1);
      if (k == 640) check("d_act_640", 32'(d_active), 0);
      if (k == 655) check("d_hs_655", 32'(d_hsync), 1);
      if (k == 656) check("d_hs_656", 32'(d_hsync), 0);
      if (k == 751) check("d_hs_751", 32'(d_hsync), 0);
      if (k == 752) check("d_hs_752", 32'(d_hsync), 1);
      if (k == 799) begin
        check("d_h_799", 32'(d_hcount), 799);
        check("d_ls_799", 32'(d_ls), 0);
      end
      if (k == 800) begin
        check("d_wrap_h", 32'(d_hcount), 0);
        check("d_wrap_v", 32'(d_vcount), 1);
        check("d_wrap_ls", 32'(d_ls), 1);
        check("d_wrap_fs", 32'(d_fs), 0);
      end
    end
    check("frame_active_cnt", act_n, 24);
    check("frame_hsync_cnt", hs_n, 27);
    check("frame_vsync_cnt", vs_n, 26);
    check("frame_ls_cnt", ls_n, 9);
    check("frame_fs_cnt", fs_n, 1);

    // Run to hcount=300 then reset for one clk with pix_ce high.
    guard = 0;
    while (d_hcount != 10'd300 && guard < 1000) begin
      cycle(1'b1);
      check_small(1'b1);
      guard++;
    end
    check("reach_h300", 32'(d_hcount), 300);
    check("reach_v1", 32'(d_vcount), 1);
    rst = 1'b1;
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrst");
    rst = 1'b0;
    s = -1;
    k = -1;
    cycle(1'b1);
    check_small(1'b1);
    check("post_rst_h", 32'(d_hcount), 0);
    check("post_rst_v", 32'(d_vcount), 0);
    check("post_rst_fs", 32'(d_fs), 1);

    // pix_ce one clk in four: holds, one-clk strobes and frame period.
    fs_clk = -1;
    ls_n = 0;
    for (int c = 1; c <= 520; c++) begin
      cycle(c % 4 == 0);
      check_small(c % 4 == 0);
      ls_n += int'(s_ls);
      if (s_fs && fs_clk < 0) fs_clk = c;
    end
    check("fs_period_1in4", fs_clk, 468);
    check("ls_cnt_1in4", ls_n, 10);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
